sram_1r1w_param_ext: RTL and testbench

Parametrised single-clock 1R1W behavioural SRAM. It succeeds the fixed-geometry `*_ext` macros used by caches, scratchpads and backing memory, with the following generalisations:
- configurable width, depth and mask granularity;
- configurable read latency;
- write-to-read bypass on address collision;
- a hardware initialisation sweep after reset, with deterministic contents and no `$random`.

It is instantiated by the memory-macro wrapper layer wherever a deterministic, reset-initialised array is required.

---
 rtl/sram_1r1w_param_ext.sv | 138 +++++++++++++
 tb/tb_sram_1r1w_param_ext.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_param_ext.sv
// Single-clock 1R1W behavioural SRAM: lane-masked writes, pipelined in-order reads,
// optional write-to-read bypass and a deterministic fill sweep after every reset.
module sram_1r1w_param_ext #(
  parameter int                DEPTH     = 512,
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 64,
  parameter int                MASK_GRAN = 8,
  parameter int                RD_LAT    = 1,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        W0_en,
  input  logic [ADDR_W-1:0]           W0_addr,
  input  logic [DATA_W-1:0]           W0_data,
  input  logic [DATA_W/MASK_GRAN-1:0] W0_mask,
  input  logic                        R0_en,
  input  logic [ADDR_W-1:0]           R0_addr,
  output logic [DATA_W-1:0]           R0_data,
  output logic                        R0_valid,
  output logic                        init_busy
);
  localparam int               MASK_W   = DATA_W / MASK_GRAN;
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_fire;
  logic              rd_fire;
  logic              rd_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] last_data;
  logic              last_vld;

  assign ready       = (state == ST_READY);
  assign w_idx       = W0_addr[IDX_W-1:0];
  assign r_idx       = R0_addr[IDX_W-1:0];
  assign rd_in_range = ({1'b0, R0_addr} < DEPTH_X);
  assign wr_fire     = ready && W0_en && ({1'b0, W0_addr} < DEPTH_X);
  assign rd_fire     = ready && R0_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else if (state == ST_INIT) begin
      cnt <= cnt + IDX_W'(1);
      if (cnt == LAST_IDX) begin
        state     <= ST_READY;
        init_busy <= 1'b0;
      end
    end
  end

  // Storage is never reset; the sweep owns the write port until it completes.
  always_ff @(posedge clock) begin
    if (!ready) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_fire) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) begin
          mem[w_idx][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  // Stage p0: array read, merged with the same-edge write when bypass is enabled.
  always_comb begin
    rd_word = mem[r_idx];
    if ((BYPASS != 0) && wr_fire && (W0_addr == R0_addr)) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (W0_mask[i]) begin
          rd_word[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
    if (!rd_in_range) begin
      rd_word = '0;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign last_data = rd_word;
      assign last_vld  = rd_fire;
    end else begin : g_latn
      logic [DATA_W-1:0] data_p [RD_LAT-1];
      logic [RD_LAT-2:0] vld_p;

      // Stages p0..p(RD_LAT-2): delay line ahead of the output register.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= rd_fire;
          for (int k = 1; k < RD_LAT - 1; k++) begin
            vld_p[k] <= vld_p[k-1];
          end
        end
      end

      always_ff @(posedge clock) begin
        data_p[0] <= rd_word;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          data_p[k] <= data_p[k-1];
        end
      end

      assign last_data = data_p[RD_LAT-2];
      assign last_vld  = vld_p[RD_LAT-2];
    end
  endgenerate

  // Output stage: data only moves with a valid result, otherwise it holds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      R0_valid <= 1'b0;
      R0_data  <= '0;
    end else begin
      R0_valid <= last_vld;
      if (last_vld) begin
        R0_data <= last_data;
      end
    end
  end
endmodule

// File: tb/tb_sram_1r1w_param_ext.sv
// Directed bench for sram_1r1w_param_ext: three 16-word instances (latency 1/3/2,
// bypass on/off) exercised one at a time from a shared request bus.
module tb_sram_1r1w_param_ext;
  localparam logic [63:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  logic        clock = 1'b0;
  logic        rst_a, rst_b, rst_c;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_mask;
  logic        r_en;
  logic [4:0]  r_addr;
  logic [63:0] rd_data  [3];
  logic        rd_valid [3];
  logic        busy     [3];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        re;
    logic [4:0]  ra;
    logic        ev;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl [14];

  always #5 clock = ~clock;

  sram_1r1w_param_ext #(.DEPTH(16), .ADDR_W(5), .DATA_W(64), .MASK_GRAN(8),
                        .RD_LAT(1), .BYPASS(1), .INIT_VAL(A5)) dut_a (
    .clock(clock), .reset_n(rst_a), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data),
    .W0_mask(w_mask), .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd_data[0]),
    .R0_valid(rd_valid[0]), .init_busy(busy[0]));

  sram_1r1w_param_ext #(.DEPTH(16), .ADDR_W(5), .DATA_W(64), .MASK_GRAN(8),
                        .RD_LAT(3), .BYPASS(0), .INIT_VAL(64'h0)) dut_b (
    .clock(clock), .reset_n(rst_b), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data),
    .W0_mask(w_mask), .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd_data[1]),
    .R0_valid(rd_valid[1]), .init_busy(busy[1]));

  sram_1r1w_param_ext #(.DEPTH(16), .ADDR_W(5), .DATA_W(64), .MASK_GRAN(8),
                        .RD_LAT(2), .BYPASS(1), .INIT_VAL(64'h0)) dut_c (
    .clock(clock), .reset_n(rst_c), .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data),
    .W0_mask(w_mask), .R0_en(r_en), .R0_addr(r_addr), .R0_data(rd_data[2]),
    .R0_valid(rd_valid[2]), .init_busy(busy[2]));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    w_en = 1'b0; w_addr = '0; w_data = '0; w_mask = '0;
    r_en = 1'b0; r_addr = '0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] m);
    w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
  endtask

  // Counts edges until init_busy drops; requests are injected on the third sweep edge.
  task automatic sweep(input int which, output int cycles, output bit saw);
    cycles = 0;
    saw    = 1'b0;
    while (busy[which] && cycles < 100) begin
      if (cycles == 2) begin
        drive_write(5'd2, '1, 8'hFF);
        r_en = 1'b1; r_addr = 5'd2;
      end
      step();
      idle_bus();
      cycles++;
      if (rd_valid[which]) saw = 1'b1;
    end
  endtask

  // Issues one read (plus whatever write is already on the bus) and waits for its result.
  task automatic do_read(input int which, input logic [4:0] addr, input int lat,
                         input logic [63:0] exp, input string name);
    int n;
    bit got;
    r_en = 1'b1; r_addr = addr;
    step();
    idle_bus();
    n   = 1;
    got = rd_valid[which];
    while (!got && n < 8) begin
      step();
      n++;
      got = rd_valid[which];
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    check({name, "_data"}, rd_data[which], exp);
  endtask

  initial begin
    int cyc;
    bit saw;
    logic [7:0] vpat;

    tbl[0]  = '{1'b1, 5'd5,  64'h1122334455667788, 8'hFF, 1'b0, 5'd0,  1'b0, A5};
    tbl[1]  = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd5,  1'b1, 64'h1122334455667788};
    tbl[2]  = '{1'b1, 5'd7,  64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1, 5'd7,  1'b1, 64'hA5A5A5A5FFFFFFFF};
    tbl[3]  = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd7,  1'b1, 64'hA5A5A5A5FFFFFFFF};
    tbl[4]  = '{1'b1, 5'd3,  64'hDEADBEEF00000000, 8'hF0, 1'b1, 5'd3,  1'b1, 64'hDEADBEEFA5A5A5A5};
    tbl[5]  = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd3,  1'b1, 64'hDEADBEEFA5A5A5A5};
    tbl[6]  = '{1'b1, 5'd9,  64'h0102030405060708, 8'h00, 1'b1, 5'd9,  1'b1, A5};
    tbl[7]  = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd17, 1'b1, 64'h0};
    tbl[8]  = '{1'b1, 5'd20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 5'd4,  1'b1, A5};
    tbl[9]  = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd4,  1'b1, A5};
    tbl[10] = '{1'b1, 5'd10, 64'h1111111111111111, 8'hFF, 1'b0, 5'd0,  1'b0, A5};
    tbl[11] = '{1'b1, 5'd10, 64'h2222222222222222, 8'h0F, 1'b0, 5'd0,  1'b0, A5};
    tbl[12] = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b1, 5'd10, 1'b1, 64'h1111111122222222};
    tbl[13] = '{1'b0, 5'd0,  64'h0,                8'h00, 1'b0, 5'd0,  1'b0, 64'h1111111122222222};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    idle_bus();
    repeat (3) step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst%0d_valid", d), 64'(rd_valid[d]), 64'h0);
      check($sformatf("rst%0d_data", d), rd_data[d], 64'h0);
      check($sformatf("rst%0d_busy", d), 64'(busy[d]), 64'h1);
    end

    // Instance A: latency 1, bypass, A5 fill
    rst_a = 1'b1;
    sweep(0, cyc, saw);
    check("a_sweep_cycles", 64'(cyc), 64'd16);
    check("a_init_no_valid", 64'(saw), 64'h0);
    for (int a = 0; a < 16; a++) do_read(0, 5'(a), 1, A5, $sformatf("a_init_word%0d", a));
    for (int i = 0; i < 14; i++) begin
      w_en = tbl[i].we; w_addr = tbl[i].wa; w_data = tbl[i].wd; w_mask = tbl[i].wm;
      r_en = tbl[i].re; r_addr = tbl[i].ra;
      step();
      check($sformatf("a_vec%0d_valid", i), 64'(rd_valid[0]), 64'(tbl[i].ev));
      check($sformatf("a_vec%0d_data", i), rd_data[0], tbl[i].ed);
    end
    idle_bus();

    // Instance B: latency 3, no bypass, zero fill
    rst_a = 1'b0;
    rst_b = 1'b1;
    sweep(1, cyc, saw);
    check("b_sweep_cycles", 64'(cyc), 64'd16);
    check("b_init_no_valid", 64'(saw), 64'h0);
    drive_write(5'd5, 64'h1122334455667788, 8'hFF);
    step();
    idle_bus();
    vpat = '0;
    for (int k = 0; k < 8; k++) begin
      r_en = (k < 4); r_addr = 5'd5;
      step();
      vpat[k] = rd_valid[1];
      if (rd_valid[1]) check($sformatf("b_burst%0d_data", k), rd_data[1], 64'h1122334455667788);
    end
    idle_bus();
    check("b_burst_valid_pattern", 64'(vpat), 64'h3C);
    drive_write(5'd7, '1, 8'h0F);
    step();
    idle_bus();
    do_read(1, 5'd7, 3, 64'h00000000FFFFFFFF, "b_partial");
    drive_write(5'd3, 64'hDEADBEEF00000000, 8'hF0);
    do_read(1, 5'd3, 3, 64'h0, "b_collide_old");
    do_read(1, 5'd3, 3, 64'hDEADBEEF00000000, "b_after_collide");

    // Instance C: latency 2, bypass, zero fill, reset during a read
    rst_b = 1'b0;
    rst_c = 1'b1;
    sweep(2, cyc, saw);
    check("c_sweep_cycles", 64'(cyc), 64'd16);
    do_read(2, 5'd17, 2, 64'h0, "c_out_of_range");
    drive_write(5'd3, 64'hDEADBEEF00000000, 8'hF0);
    do_read(2, 5'd3, 2, 64'hDEADBEEF00000000, "c_collide_bypass");
    drive_write(5'd6, '1, 8'hFF);
    step();
    idle_bus();
    r_en = 1'b1; r_addr = 5'd6;
    step();
    idle_bus();
    rst_c = 1'b0;
    #1;
    check("c_midreset_data", rd_data[2], 64'h0);
    check("c_midreset_valid", 64'(rd_valid[2]), 64'h0);
    check("c_midreset_busy", 64'(busy[2]), 64'h1);
    saw = 1'b0;
    repeat (4) begin
      step();
      if (rd_valid[2]) saw = 1'b1;
    end
    check("c_reset_no_valid", 64'(saw), 64'h0);
    rst_c = 1'b1;
    sweep(2, cyc, saw);
    check("c_resweep_cycles", 64'(cyc), 64'd16);
    check("c_resweep_no_valid", 64'(saw), 64'h0);
    do_read(2, 5'd6, 2, 64'h0, "c_word6_refilled");
    do_read(2, 5'd2, 2, 64'h0, "c_word2_init_write_ignored");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
